cnn_frame_loader: RTL



---
 rtl/cnn_frame_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cnn_frame_loader.sv
// Host byte stream to CNN core loader: sequences one weight set, then 8x8 image
// frames, waiting for the core result flag between frames.
module cnn_frame_loader #(
    parameter int W_BYTES     = 54,
    parameter int D_BYTES     = 64,
    parameter int RES_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       reload_w,
    input  logic       res_flag,
    output logic       mode,
    output logic [7:0] din,
    output logic       ram_en,
    output logic       weights_ok,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic       err_timeout
);

    // state      | meaning
    // S_IDLE     | one-cycle decision point: weights if reload pending, else image
    // S_LOAD_W   | streaming W_BYTES into weight RAM (mode=1)
    // S_LOAD_D   | streaming D_BYTES into data RAM (mode=0)
    // S_WAIT_RES | image in flight, waiting for res_flag or timeout
    localparam int CNT_MAX = (W_BYTES > D_BYTES) ? W_BYTES : D_BYTES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(RES_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD_W   = 2'd1,
        S_LOAD_D   = 2'd2,
        S_WAIT_RES = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_pend;
    logic            r_mode;
    logic [7:0]      r_din;
    logic            r_ram_en;
    logic            r_weights_ok;
    logic [7:0]      r_frame_cnt;
    logic            r_err;

    logic            w_ready;
    logic            w_busy;
    logic            w_hs;
    logic            w_last_w;
    logic            w_last_d;
    logic            w_tmo_hit;

    assign w_hs      = s_valid && w_ready;
    assign w_last_w  = (r_state == S_LOAD_W) && w_hs && (r_cnt == CW'(W_BYTES - 1));
    assign w_last_d  = (r_state == S_LOAD_D) && w_hs && (r_cnt == CW'(D_BYTES - 1));
    assign w_tmo_hit = (r_state == S_WAIT_RES) && (r_tmo == TW'(RES_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = r_pend ? S_LOAD_W : S_LOAD_D;
            S_LOAD_W:   if (w_last_w) w_next = S_IDLE;
            S_LOAD_D:   if (w_last_d) w_next = S_WAIT_RES;
            S_WAIT_RES: if (res_flag || w_tmo_hit) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_D);
        w_busy  = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_pend       <= 1'b1;
            r_mode       <= 1'b0;
            r_din        <= 8'd0;
            r_ram_en     <= 1'b0;
            r_weights_ok <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            r_ram_en <= w_hs;
            if (w_hs) begin
                r_din  <= s_data;
                r_mode <= (r_state == S_LOAD_W);
            end

            if (w_last_w || w_last_d) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if ((r_state == S_WAIT_RES) && (w_next == S_WAIT_RES)) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end

            // a request during a weight load is redundant; completion clears it
            if (w_last_w) begin
                r_pend <= 1'b0;
            end else if (reload_w && (r_state != S_LOAD_W)) begin
                r_pend <= 1'b1;
            end

            if ((r_state == S_IDLE) && (w_next == S_LOAD_W)) begin
                r_weights_ok <= 1'b0;
            end else if (w_last_w) begin
                r_weights_ok <= 1'b1;
            end

            // res_flag wins over a coincident timeout
            if ((r_state == S_WAIT_RES) && res_flag) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_ready     = w_ready;
    assign busy        = w_busy;
    assign mode        = r_mode;
    assign din         = r_din;
    assign ram_en      = r_ram_en;
    assign weights_ok  = r_weights_ok;
    assign frame_cnt   = r_frame_cnt;
    assign err_timeout = r_err;

endmodule
